// File: rtl/pixel_pkg.sv
// Shared types for the pixel readout serializer: pixel/pair formats and serializer states.
package pixel_pkg;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        pixel_t pix1;
        pixel_t pix2;
        logic   sof;
        logic   eof;
    } pix_pair_t;

    typedef enum logic [1:0] {
        StIdle,
        StSendP1,
        StSendP2
    } ser_state_t;

    localparam int unsigned DEFAULT_PAIRS_PER_FRAME = 2;

endpackage

// File: rtl/pix_pair_fifo.sv
// Synchronous FIFO of tagged pixel pairs; pointers carry an extra wrap bit for full/empty.
module pix_pair_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  pix_pair_t                wdata,
    output pix_pair_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    pix_pair_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level   = wptr_q - rptr_q;
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_readout_serializer.sv
// Tags captured pixel pairs with frame markers, buffers them and streams them out byte-wise.
module pixel_readout_serializer
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned PAIRS_PER_FRAME = DEFAULT_PAIRS_PER_FRAME
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic [7:0]             in_pix1,
    input  logic [7:0]             in_pix2,
    input  logic                   clr_overflow,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int unsigned PcW = $clog2(PAIRS_PER_FRAME + 1);
    localparam logic [PcW-1:0] PcLast = PcW'(PAIRS_PER_FRAME);

    logic [PcW-1:0] pc_q, pc_d;
    logic           tag_sof, tag_err;
    pix_pair_t      wdata, head;
    logic           full, empty, push, pop, drop;
    ser_state_t     state_q;
    pixel_t         pix2_q;
    logic           eof_q;

    // Frame tagger: a pair arriving outside a frame opens a new one and flags the error.
    always_comb begin
        pc_d    = pc_q;
        tag_sof = 1'b0;
        tag_err = 1'b0;
        if (in_valid) begin
            if (in_first) begin
                tag_sof = 1'b1;
                tag_err = (pc_q != '0) && (pc_q != PcLast);
                pc_d    = PcW'(1);
            end else if (pc_q == '0 || pc_q == PcLast) begin
                tag_sof = 1'b1;
                tag_err = 1'b1;
                pc_d    = PcW'(1);
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    assign wdata = '{pix1: in_pix1, pix2: in_pix2, sof: tag_sof, eof: (pc_d == PcLast)};
    assign pop   = !empty && ((state_q == StIdle) || (state_q == StSendP2 && out_ready));
    assign push  = in_valid && (!full || pop);
    assign drop  = in_valid && full && !pop;

    pix_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (tag_err)           frame_err <= 1'b1;
            else if (clr_overflow) frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            pix2_q    <= '0;
            eof_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q   <= StSendP1;
                        out_valid <= 1'b1;
                        out_data  <= head.pix1;
                        out_sof   <= head.sof;
                        out_eof   <= 1'b0;
                        pix2_q    <= head.pix2;
                        eof_q     <= head.eof;
                    end
                end
                StSendP1: begin
                    if (out_ready) begin
                        state_q  <= StSendP2;
                        out_data <= pix2_q;
                        out_sof  <= 1'b0;
                        out_eof  <= eof_q;
                    end
                end
                StSendP2: begin
                    if (out_ready) begin
                        if (!empty) begin
                            state_q   <= StSendP1;
                            out_valid <= 1'b1;
                            out_data  <= head.pix1;
                            out_sof   <= head.sof;
                            out_eof   <= 1'b0;
                            pix2_q    <= head.pix2;
                            eof_q     <= head.eof;
                        end else begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                            out_sof   <= 1'b0;
                            out_eof   <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout_serializer.sv
// Directed bench: expected bytes are queued at stimulus time and checked on each accepted byte.
module tb_pixel_readout_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_first, clr_overflow, out_ready;
    logic [7:0] in_pix1, in_pix2;
    logic       out_valid, out_sof, out_eof, overflow, frame_err;
    logic [7:0] out_data;
    logic [2:0] level;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pixel_readout_serializer #(
        .DEPTH           (4),
        .PAIRS_PER_FRAME (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_pix1      (in_pix1),
        .in_pix2      (in_pix2),
        .clr_overflow (clr_overflow),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .level        (level),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p1, input logic [7:0] p2, input logic first,
                        input logic keep, input logic esof, input logic eeof);
        in_pix1  = p1;
        in_pix2  = p2;
        in_first = first;
        in_valid = 1'b1;
        if (keep) begin
            sb.push_back(exp_t'{p1, esof, 1'b0});
            sb.push_back(exp_t'{p2, 1'b0, eeof});
        end
        tick(1);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick(1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle"}, out_valid, 1'b0);
    endtask

    // Scoreboard: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("extra_byte", {24'd0, out_data}, 32'hDEAD);
            end else begin
                e = sb.pop_front();
                check("byte_data", out_data, e.data);
                check("byte_sof", out_sof, e.sof);
                check("byte_eof", out_eof, e.eof);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; clr_overflow = 1'b0;
        out_ready = 1'b0; in_pix1 = '0; in_pix2 = '0;
        tick(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_sof", out_sof, 1'b0);
        check("rst_eof", out_eof, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        reset = 1'b0;
        tick(1);

        // 1: one frame, consumer always ready
        out_ready = 1'b1;
        send(8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_latency_early", out_valid, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t1_latency_valid", out_valid, 1'b1);
        drain("t1");

        // 2: back-pressure holds first byte stable
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", out_valid, 1'b1);
            check("t2_hold_data", out_data, 8'h11);
            check("t2_hold_sof", out_sof, 1'b1);
            tick(1);
        end
        check("t2_level", level, 3'd1);
        drain("t2");

        // 3: overflow with 6 pairs against a stalled consumer
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h50 + 2 * i), 8'(8'h51 + 2 * i), (i % 2) == 0, i < 5,
                 (i % 2) == 0, (i % 2) == 1);
        end
        check("t3_level", level, 3'd4);
        check("t3_overflow", overflow, 1'b1);
        check("t3_no_frame_err", frame_err, 1'b0);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("t3_overflow_clr", overflow, 1'b0);
        drain("t3");

        // 4: two frame starts in a row
        out_ready = 1'b1;
        send(8'hA1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_no_err_yet", frame_err, 1'b0);
        send(8'hB1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_frame_err", frame_err, 1'b1);
        drain("t4");
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("t4_frame_err_clr", frame_err, 1'b0);

        // 5: reset while the second byte of a pair is pending
        out_ready = 1'b0;
        send(8'hC1, 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back(exp_t'{8'hC1, 1'b1, 1'b0});
        send(8'hD1, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t5_in_p2", out_data, 8'hC2);
        check("t5_level_before", level, 3'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_level", level, 3'd0);
        check("t5_sb_consumed", sb.size(), 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        out_ready = 1'b1;
        send(8'hE1, 8'hE2, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'hF1, 8'hF2, 1'b0, 1'b1, 1'b0, 1'b1);
        drain("t5");
        check("t5_frame_err", frame_err, 1'b0);
        check("t5_overflow", overflow, 1'b0);

        // 6: push into a full FIFO in the same cycle as a pop
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h70 + 2 * i), 8'(8'h71 + 2 * i), (i % 2) == 0, 1'b1,
                 (i % 2) == 0, (i % 2) == 1);
        end
        check("t6_full", level, 3'd4);
        out_ready = 1'b1;
        tick(1);
        send(8'h7A, 8'h7B, 1'b0, 1'b1, 1'b0, 1'b1);
        out_ready = 1'b0;
        check("t6_level_kept", level, 3'd4);
        check("t6_no_drop", overflow, 1'b0);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
